readout_scheduler: RTL and testbench
====================================

READOUT_SCHEDULER -- requirements
Module: readout_scheduler

Interface
REQ-001 SHALL have parameter CELL_COUNT, default 2: number of cell links writing the readout DPRAM.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 80: maximum collect window in clk cycles; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port faStrobe  input  1  one-cycle pulse requesting a new readout cycle.
REQ-006 SHALL have port cellEnable  input  CELL_COUNT  per-cell participation mask.
REQ-007 SHALL have port cellDone  input  CELL_COUNT  per-cell pulse: cell's data fully written to DPRAM.
REQ-008 SHALL have port streamBusy  input  1  high while the downstream readout stream is still emitting packets.
REQ-009 SHALL have port readoutActive  output  1  collect window open; drives the stream's readoutActive.
REQ-010 SHALL have port readoutValid  output  1  one-cycle pulse: DPRAM contents complete, start streaming.
REQ-011 SHALL have port cellMissing  output  CELL_COUNT  enabled cells not reported at the last timeout.
REQ-012 SHALL have port completeCount  output  16  completed-cycle count.
REQ-013 SHALL have port timeoutCount  output  16  timed-out-cycle count.
REQ-014 SHALL have port overrunCount  output  16  rejected-faStrobe count.

Function
REQ-015 SHALL implement states IDLE, COLLECT, PUBLISH, DRAIN; readoutActive=1 only in COLLECT, readoutValid=1 only in PUBLISH.
REQ-016 IDLE: faStrobe=1, streamBusy=0, cellEnable!=0 -> COLLECT next cycle; register cellEnable into enMask, clear seen mask, clear timer.
REQ-017 IDLE: faStrobe with cellEnable==0 -> ignored, stays IDLE, no counter change.
REQ-018 faStrobe in any state other than IDLE, or in IDLE with streamBusy=1 -> ignored, overrunCount +1.
REQ-019 Latency: faStrobe accepted at edge N -> readoutActive high from cycle N+1.
REQ-020 COLLECT: each cycle seen |= cellDone & enMask; cellDone bits outside enMask and cellDone in other states ignored.
REQ-021 COLLECT: when (seen | (cellDone & enMask)) == enMask -> PUBLISH next cycle; completeCount +1.
REQ-022 COLLECT: timer increments each cycle; on the TIMEOUT_CYCLES-th COLLECT cycle without completion -> IDLE; timeoutCount +1; cellMissing <= enMask & ~seen (including that cycle's cellDone).
REQ-023 Completion and timeout in the same cycle -> completion wins; no timeout counted.
REQ-024 readoutActive high for at most TIMEOUT_CYCLES consecutive cycles.
REQ-025 PUBLISH lasts exactly one cycle -> DRAIN; readoutActive=0 during PUBLISH.
REQ-026 DRAIN: stay while streamBusy=1; minimum one DRAIN cycle; first cycle with streamBusy=0 -> IDLE next cycle.
REQ-027 cellMissing changes only at timeout or reset; completion leaves it unchanged.
REQ-028 All counters saturate at 16'hFFFF; no wrap.
REQ-029 cellEnable changes outside IDLE do not affect the cycle in progress.

Reset
REQ-030 reset=1 at any edge, any state -> IDLE next cycle; readoutActive=0, readoutValid=0, cellMissing=0, all counters=0, seen/enMask/timer=0.
REQ-031 reset has priority over faStrobe and cellDone in the same cycle; a cycle aborted by reset counts nothing.

Verification
REQ-032 CELL_COUNT=2, cellEnable=2'b11, faStrobe, no cellDone -> readoutActive high exactly 80 cycles, no readoutValid, timeoutCount=1, cellMissing=2'b11.
REQ-033 faStrobe, cellDone=2'b01 at cycle 3, 2'b10 at cycle 10 -> readoutActive falls at cycle 11, readoutValid one-cycle pulse at cycle 11, completeCount=1, cellMissing unchanged.
REQ-034 cellDone=2'b10 arriving on cycle 80 with 2'b01 seen earlier -> completion, completeCount=1, timeoutCount=0.
REQ-035 faStrobe during COLLECT and during DRAIN with streamBusy=1 -> both ignored, overrunCount=2, sequencing unaffected; IDLE only after streamBusy falls.
REQ-036 reset asserted mid-COLLECT after cellDone=2'b01 -> next cycle readoutActive=0, all counters 0; subsequent faStrobe starts a clean cycle.
REQ-037 cellEnable=2'b01, cellDone=2'b10 only -> timeout, cellMissing=2'b01; with cellEnable=0, faStrobe -> no activity.

Source files
------------

// File: rtl/readout_scheduler.sv
// Readout scheduler: opens a collect window when a readout is requested,
// waits for every enabled cell link to report its data written to the DPRAM,
// then publishes a one-cycle "data complete" pulse and holds off new
// requests until the downstream stream has drained. A window that does not
// complete within TIMEOUT_CYCLES is abandoned, and the cells that never
// reported are latched into cellMissing.
//
// TIMEOUT_CYCLES legal range is 2..65535. The timer is 16 bits wide.
module readout_scheduler #(
  parameter int CELL_COUNT     = 2,
  parameter int TIMEOUT_CYCLES = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  faStrobe,
  input  logic [CELL_COUNT-1:0] cellEnable,
  input  logic [CELL_COUNT-1:0] cellDone,
  input  logic                  streamBusy,
  output logic                  readoutActive,
  output logic                  readoutValid,
  output logic [CELL_COUNT-1:0] cellMissing,
  output logic [15:0]           completeCount,
  output logic [15:0]           timeoutCount,
  output logic [15:0]           overrunCount
);

  // The timer holds 0 in the first collect cycle, so the TIMEOUT_CYCLES-th
  // collect cycle is the one where the timer reads TIMEOUT_CYCLES-1.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t                state_reg;
  logic [CELL_COUNT-1:0] en_mask_reg;
  logic [CELL_COUNT-1:0] seen_reg;
  logic [15:0]           timer_reg;

  // Seen mask including this cycle's reports, and the cells still missing
  // if the window were to close right now.
  logic [CELL_COUNT-1:0] seen_next;
  logic [CELL_COUNT-1:0] missing_next;
  logic                  all_seen;
  logic                  timer_expired;
  logic                  strobe_accept;
  logic                  strobe_overrun;

  genvar gi;
  generate
    for (gi = 0; gi < CELL_COUNT; gi++) begin : g_cell
      // Reports from cells outside the latched mask never count.
      assign seen_next[gi]    = seen_reg[gi] | (cellDone[gi] & en_mask_reg[gi]);
      assign missing_next[gi] = en_mask_reg[gi] & ~seen_next[gi];
    end
  endgenerate

  assign all_seen      = (seen_next == en_mask_reg);
  assign timer_expired = (timer_reg == TIMER_LAST);

  // A request with an empty participation mask is silently dropped; a
  // request while busy (any non-idle state, or stream still emitting) is
  // counted as an overrun.
  assign strobe_accept  = faStrobe && (state_reg == IDLE) && !streamBusy
                          && (cellEnable != '0);
  assign strobe_overrun = faStrobe && ((state_reg != IDLE) || streamBusy);

  // Saturating increment for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // Sequencer with registered outputs and statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      en_mask_reg   <= '0;
      seen_reg      <= '0;
      timer_reg     <= '0;
      readoutActive <= 1'b0;
      readoutValid  <= 1'b0;
      cellMissing   <= '0;
      completeCount <= '0;
      timeoutCount  <= '0;
      overrunCount  <= '0;
    end else begin
      readoutValid <= 1'b0;

      if (strobe_overrun) begin
        overrunCount <= sat_inc(overrunCount);
      end

      case (state_reg)
        IDLE: begin
          readoutActive <= 1'b0;
          if (strobe_accept) begin
            state_reg     <= COLLECT;
            en_mask_reg   <= cellEnable;
            seen_reg      <= '0;
            timer_reg     <= '0;
            readoutActive <= 1'b1;
          end
        end

        COLLECT: begin
          seen_reg <= seen_next;
          if (all_seen) begin
            // Completion takes priority over a simultaneous timeout.
            state_reg     <= PUBLISH;
            readoutActive <= 1'b0;
            readoutValid  <= 1'b1;
            completeCount <= sat_inc(completeCount);
          end else if (timer_expired) begin
            state_reg     <= IDLE;
            readoutActive <= 1'b0;
            timeoutCount  <= sat_inc(timeoutCount);
            cellMissing   <= missing_next;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end

        PUBLISH: begin
          state_reg <= DRAIN;
        end

        DRAIN: begin
          if (!streamBusy) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          readoutActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_scheduler.sv
// Directed testbench for readout_scheduler (CELL_COUNT=2, TIMEOUT_CYCLES=80).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_readout_scheduler;

  logic        clk;
  logic        reset;
  logic        faStrobe;
  logic [1:0]  cellEnable;
  logic [1:0]  cellDone;
  logic        streamBusy;
  logic        readoutActive;
  logic        readoutValid;
  logic [1:0]  cellMissing;
  logic [15:0] completeCount;
  logic [15:0] timeoutCount;
  logic [15:0] overrunCount;

  int checks_count   = 0;
  int failures_count = 0;

  readout_scheduler #(
    .CELL_COUNT     (2),
    .TIMEOUT_CYCLES (80)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .faStrobe      (faStrobe),
    .cellEnable    (cellEnable),
    .cellDone      (cellDone),
    .streamBusy    (streamBusy),
    .readoutActive (readoutActive),
    .readoutValid  (readoutValid),
    .cellMissing   (cellMissing),
    .completeCount (completeCount),
    .timeoutCount  (timeoutCount),
    .overrunCount  (overrunCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks_count++;
    if (got !== exp) begin
      failures_count++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one full clock cycle, ending on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One-cycle request pulse; returns at the first cycle after acceptance.
  task automatic strobe();
    faStrobe = 1'b1;
    tick();
    faStrobe = 1'b0;
  endtask

  // Count consecutive readoutActive cycles starting now (bounded).
  task automatic count_active(output int n, output bit valid_seen);
    n = 0;
    valid_seen = 1'b0;
    while (readoutActive === 1'b1 && n < 200) begin
      if (readoutValid === 1'b1) valid_seen = 1'b1;
      n++;
      tick();
    end
    if (readoutValid === 1'b1) valid_seen = 1'b1;
  endtask

  task automatic check_counters(input string tag, input int c, input int t,
                                input int o);
    check_value({tag, "_complete"}, 32'(completeCount), 32'(c));
    check_value({tag, "_timeout"},  32'(timeoutCount),  32'(t));
    check_value({tag, "_overrun"},  32'(overrunCount),  32'(o));
  endtask

  int n_active;
  bit valid_seen;

  initial begin
    reset      = 1'b1;
    faStrobe   = 1'b0;
    cellEnable = 2'b00;
    cellDone   = 2'b00;
    streamBusy = 1'b0;
    @(negedge clk);
    ticks(2);
    reset = 1'b0;

    // Reset state
    check_value("rst_active",  32'(readoutActive), 32'd0);
    check_value("rst_valid",   32'(readoutValid),  32'd0);
    check_value("rst_missing", 32'(cellMissing),   32'd0);
    check_counters("rst", 0, 0, 0);
    $display("txn reset: state checked");

    // Full timeout with no reports
    cellEnable = 2'b11;
    strobe();
    check_value("to_latency", 32'(readoutActive), 32'd1);
    count_active(n_active, valid_seen);
    check_value("to_active_len", 32'(n_active), 32'd80);
    check_value("to_no_valid", 32'(valid_seen), 32'd0);
    check_value("to_missing", 32'(cellMissing), 32'd3);
    check_counters("to", 0, 1, 0);
    $display("txn timeout: active_cycles=%0d missing=%b", n_active, cellMissing);

    // Completion at collect cycle 10; cellMissing must stay 2'b11
    tick();
    strobe();                        // collect cycle 1
    ticks(2);                        // cycle 3
    cellDone = 2'b01;
    tick();                          // cycle 4
    cellDone = 2'b00;
    ticks(6);                        // cycle 10
    check_value("cmp_active_c10", 32'(readoutActive), 32'd1);
    cellDone = 2'b10;
    tick();                          // cycle 11
    cellDone = 2'b00;
    check_value("cmp_active_c11", 32'(readoutActive), 32'd0);
    check_value("cmp_valid_c11",  32'(readoutValid),  32'd1);
    tick();                          // cycle 12
    check_value("cmp_valid_c12",  32'(readoutValid),  32'd0);
    check_value("cmp_missing", 32'(cellMissing), 32'd3);
    check_counters("cmp", 1, 1, 0);
    $display("txn complete: completeCount=%0d missing=%b", completeCount, cellMissing);
    tick();                          // back to IDLE

    // Completion on the 80th collect cycle beats the timeout
    do_reset();
    strobe();                        // cycle 1
    tick();                          // cycle 2
    cellDone = 2'b01;
    tick();                          // cycle 3
    cellDone = 2'b00;
    ticks(77);                       // cycle 80
    check_value("edge_active_c80", 32'(readoutActive), 32'd1);
    cellDone = 2'b10;
    tick();                          // cycle 81
    cellDone = 2'b00;
    check_value("edge_valid", 32'(readoutValid), 32'd1);
    check_value("edge_active_c81", 32'(readoutActive), 32'd0);
    check_counters("edge", 1, 0, 0);
    $display("txn edge_complete: completeCount=%0d timeoutCount=%0d",
             completeCount, timeoutCount);
    ticks(2);

    // Overruns during COLLECT and busy DRAIN
    do_reset();
    strobe();                        // cycle 1
    tick();                          // cycle 2
    faStrobe = 1'b1;
    tick();                          // cycle 3
    faStrobe = 1'b0;
    cellDone = 2'b11;
    tick();                          // cycle 4: PUBLISH
    cellDone = 2'b00;
    check_value("ovr_valid", 32'(readoutValid), 32'd1);
    streamBusy = 1'b1;
    tick();                          // cycle 5: DRAIN
    faStrobe = 1'b1;
    tick();                          // cycle 6
    faStrobe = 1'b0;
    check_value("ovr_active_drain", 32'(readoutActive), 32'd0);
    tick();                          // cycle 7
    check_value("ovr_count", 32'(overrunCount), 32'd2);
    streamBusy = 1'b0;
    tick();                          // cycle 8: IDLE
    check_value("ovr_idle_active", 32'(readoutActive), 32'd0);
    strobe();                        // cycle 9: new window
    check_value("ovr_restart", 32'(readoutActive), 32'd1);
    check_counters("ovr", 1, 0, 2);
    $display("txn overrun: overrunCount=%0d", overrunCount);

    // Reset mid-collect, with a completing report in the same cycle
    cellDone = 2'b01;
    tick();
    cellDone = 2'b10;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cellDone = 2'b00;
    check_value("rmid_active", 32'(readoutActive), 32'd0);
    check_value("rmid_valid",  32'(readoutValid),  32'd0);
    check_counters("rmid", 0, 0, 0);
    strobe();                        // clean cycle 1
    cellDone = 2'b10;
    tick();                          // cycle 2
    cellDone = 2'b00;
    check_value("rmid_clean_active", 32'(readoutActive), 32'd1);
    check_value("rmid_clean_valid",  32'(readoutValid),  32'd0);
    cellDone = 2'b01;
    tick();                          // cycle 3
    cellDone = 2'b00;
    check_value("rmid_clean_done", 32'(readoutValid), 32'd1);
    $display("txn reset_mid: completeCount=%0d", completeCount);
    ticks(2);

    // Single enabled cell, only the other cell reports; mask change ignored
    do_reset();
    cellEnable = 2'b01;
    strobe();
    cellDone = 2'b10;
    cellEnable = 2'b11;
    count_active(n_active, valid_seen);
    cellDone = 2'b00;
    check_value("mask_active_len", 32'(n_active), 32'd80);
    check_value("mask_missing", 32'(cellMissing), 32'd1);
    check_counters("mask", 0, 1, 0);
    $display("txn mask: missing=%b", cellMissing);

    // Empty participation mask: request dropped, nothing counted
    cellEnable = 2'b00;
    strobe();
    check_value("empty_active", 32'(readoutActive), 32'd0);
    tick();
    check_value("empty_active2", 32'(readoutActive), 32'd0);
    check_counters("empty", 0, 1, 0);
    $display("txn empty_mask: readoutActive=%0d", readoutActive);

    $display("TB_RESULT checks=%0d failures=%0d", checks_count, failures_count);
    $finish;
  end

endmodule
